// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared op/state encodings and signedness mapping for the multiply controller
package rv32m_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  // is_signed bit1 qualifies rs1, bit0 qualifies rs2
  localparam logic [1:0] SGN_MUL    = 2'b00;
  localparam logic [1:0] SGN_MULH   = 2'b11;
  localparam logic [1:0] SGN_MULHSU = 2'b10;
  localparam logic [1:0] SGN_MULHU  = 2'b00;

  function automatic logic [1:0] sign_mode(input op_t o);
    case (o)
      OP_MULH:   return SGN_MULH;
      OP_MULHSU: return SGN_MULHSU;
      OP_MULHU:  return SGN_MULHU;
      default:   return SGN_MUL;
    endcase
  endfunction

endpackage

// File: rtl/pp_mul32.sv
// rtl/pp_mul32.sv - fixed-latency 32x32->64 multiplier datapath with a one-cycle finished pulse
module pp_mul32 #(
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [1:0]  is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        finished,
  output logic [63:0] product
);
  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;
  logic [63:0]   a_ext;
  logic [63:0]   b_ext;

  // Sign-extend to 64 bits so the modulo-2^64 product is the correct signed/unsigned result
  assign a_ext = {{32{is_signed[1] & a[31]}}, a};
  assign b_ext = {{32{is_signed[0] & b[31]}}, b};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      finished <= 1'b0;
      product  <= '0;
    end else if (start) begin
      cnt      <= CW'(LATENCY - 1);
      finished <= (LATENCY == 1);
      product  <= a_ext * b_ext;
    end else begin
      finished <= (cnt == CW'(1));
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - request/response sequencer around pp_mul32 with timeout and flush
// Define MUL_RESULT_CACHE_EN to add a one-entry result cache that bypasses the multiplier on a hit.
module mul_seq_ctrl
  import rv32m_pkg::*;
#(
  parameter int MAX_WAIT    = 8,
  parameter int MUL_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t        state, state_nx;
  op_t           op_q;
  logic [1:0]    sgn_q;
  logic [31:0]   rs1_q, rs2_q;
  logic [63:0]   prod_q, mul_product, hit_prod;
  logic [CW-1:0] wait_cnt;
  logic          err_q, start, finished, accept, hit, timeout;

  // flush wins over any handshake in the same cycle
  assign req_ready  = (state == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign start      = (state == ISSUE) && !flush;
  assign timeout    = (state == WAIT) && !finished && (wait_cnt == CW'(MAX_WAIT));
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP) && !flush;
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (state != RESP || err_q) ? '0 :
                      (op_q == OP_MUL) ? prod_q[31:0] : prod_q[63:32];

`ifdef MUL_RESULT_CACHE_EN
  logic        c_valid;
  logic [31:0] c_rs1, c_rs2;
  logic [1:0]  c_sgn;
  logic [63:0] c_prod;

  assign hit = c_valid && (rs1 == c_rs1) && (rs2 == c_rs2) &&
               ((op_t'(op) == OP_MUL) || (sign_mode(op_t'(op)) == c_sgn));
  assign hit_prod = c_prod;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_sgn   <= '0;
      c_prod  <= '0;
    end else if (flush || timeout) begin
      c_valid <= 1'b0;
    end else if (state == CAPTURE) begin
      c_valid <= 1'b1;
      c_rs1   <= rs1_q;
      c_rs2   <= rs2_q;
      c_sgn   <= sgn_q;
      c_prod  <= mul_product;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_prod = '0;
`endif

  pp_mul32 #(.LATENCY(MUL_LATENCY)) u_mul (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .is_signed (sgn_q),
    .a         (rs1_q),
    .b         (rs2_q),
    .finished  (finished),
    .product   (mul_product)
  );

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = hit ? RESP : ISSUE;
        ISSUE:   state_nx = WAIT;
        WAIT:    if (finished) state_nx = CAPTURE;
                 else if (timeout) state_nx = RESP;
        CAPTURE: state_nx = RESP;
        RESP:    if (resp_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      sgn_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= op_t'(op);
        sgn_q <= sign_mode(op_t'(op));
        rs1_q <= rs1;
        rs2_q <= rs2;
        err_q <= 1'b0;
        if (hit) prod_q <= hit_prod;
      end
      // wait_cnt holds the number of cycles elapsed since the start pulse
      if (state == ISSUE) wait_cnt <= CW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (state == CAPTURE && !flush) prod_q <= mul_product;
      if (timeout && !flush) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl; instance d1 never finishes within its MAX_WAIT
`timescale 1ns/1ps
module tb_mul_seq_ctrl;
  localparam int MW0 = 8, LAT0 = 4, MW1 = 4, LAT1 = 12;
`ifdef MUL_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_STARTS = 0;
`else
  localparam int HIT_LAT = 7;
  localparam int HIT_STARTS = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, flush, resp_valid, resp_ready, resp_err, busy, start_obs;
  logic [1:0][1:0]  op;
  logic [1:0][31:0] rs1, rs2, resp_data;
  int cyc = 0, total = 0, bad = 0, starts0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_ctrl #(.MAX_WAIT(MW0), .MUL_LATENCY(LAT0)) d0 (
    .CLK(clk), .nRST(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .op(op[0]),
    .rs1(rs1[0]), .rs2(rs2[0]), .flush(flush[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0]), .busy(busy[0]));

  mul_seq_ctrl #(.MAX_WAIT(MW1), .MUL_LATENCY(LAT1)) d1 (
    .CLK(clk), .nRST(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .op(op[1]),
    .rs1(rs1[1]), .rs2(rs2[1]), .flush(flush[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1]), .busy(busy[1]));

  assign start_obs[0] = d0.start;
  assign start_obs[1] = d1.start;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int mw(input int d);
    return (d == 0) ? MW0 : MW1;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [1:0] sgn_of(input logic [1:0] o);
    case (o)
      2'b01:   return 2'b11;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [63:0] full_prod(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = s[1] ? longint'($signed(a)) : longint'({32'b0, a});
    y = s[0] ? longint'($signed(b)) : longint'({32'b0, b});
    return x * y;
  endfunction

  // Transaction-level model: each accepted request yields one response at a fixed cycle
  bit          m_busy[2], m_hit[2], m_err[2], c_ok[2];
  int          m_acc[2], m_at[2];
  logic [1:0]  m_op[2], c_sgn[2];
  logic [31:0] m_a[2], m_b[2], c_a[2], c_b[2];
  logic [63:0] m_p[2], c_p[2];

  always @(negedge clk) begin
    if (start_obs[0]) starts0++;
    for (int d = 0; d < 2; d++) begin
      logic e_ready, e_valid, e_start;
      logic [31:0] e_data;
      if (!rst_n) begin
        chk($sformatf("d%0d reset resp_valid", d), resp_valid[d], 0);
        chk($sformatf("d%0d reset busy", d), busy[d], 0);
        m_busy[d] = 0;
        c_ok[d] = 0;
      end else begin
        e_ready = !m_busy[d] && !flush[d];
        e_valid = m_busy[d] && (cyc >= m_at[d]) && !flush[d];
        e_start = m_busy[d] && !m_hit[d] && (cyc == m_acc[d] + 1) && !flush[d];
        chk($sformatf("d%0d req_ready", d), req_ready[d], e_ready);
        chk($sformatf("d%0d resp_valid", d), resp_valid[d], e_valid);
        chk($sformatf("d%0d busy", d), busy[d], m_busy[d]);
        chk($sformatf("d%0d start", d), start_obs[d], e_start);
        if (e_valid) begin
          e_data = m_err[d] ? 32'h0 : (m_op[d] == 2'b00) ? m_p[d][31:0] : m_p[d][63:32];
          chk($sformatf("d%0d resp_data", d), resp_data[d], e_data);
          chk($sformatf("d%0d resp_err", d), resp_err[d], m_err[d]);
        end
        if (flush[d]) begin
          m_busy[d] = 0;
          c_ok[d] = 0;
        end else if (e_valid && resp_ready[d]) begin
          m_busy[d] = 0;
          if (m_err[d]) c_ok[d] = 0;
          else if (!m_hit[d]) begin
            c_ok[d] = 1; c_a[d] = m_a[d]; c_b[d] = m_b[d];
            c_sgn[d] = sgn_of(m_op[d]); c_p[d] = m_p[d];
          end
        end else if (e_ready && req_valid[d]) begin
          m_busy[d] = 1; m_acc[d] = cyc; m_op[d] = op[d]; m_a[d] = rs1[d]; m_b[d] = rs2[d];
          m_hit[d] = 0;
`ifdef MUL_RESULT_CACHE_EN
          m_hit[d] = c_ok[d] && (rs1[d] == c_a[d]) && (rs2[d] == c_b[d]) &&
                     ((op[d] == 2'b00) || (sgn_of(op[d]) == c_sgn[d]));
`endif
          if (m_hit[d]) begin
            m_p[d] = c_p[d]; m_err[d] = 0; m_at[d] = cyc + 1;
          end else if (lat(d) <= mw(d)) begin
            m_p[d] = full_prod(sgn_of(op[d]), rs1[d], rs2[d]); m_err[d] = 0; m_at[d] = cyc + lat(d) + 3;
          end else begin
            m_p[d] = '0; m_err[d] = 1; m_at[d] = cyc + mw(d) + 2;
          end
        end
      end
    end
  end

  task automatic do_req(input int d, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] x_data, input logic x_err, input int x_lat, input int hold,
                        input string nm);
    int t_acc, n;
    logic [31:0] held;
    op[d] = o; rs1[d] = a; rs2[d] = b; req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 40) begin @(posedge clk); #1; n++; end
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (!resp_valid[d] && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " latency"}, cyc - t_acc, x_lat);
    chk({nm, " data"}, resp_data[d], x_data);
    chk({nm, " err"}, resp_err[d], x_err);
    held = resp_data[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " held data"}, resp_data[d], held);
      chk({nm, " held no accept"}, req_ready[d], 0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic flush_op(input int d, input int k, input string nm);
    int n;
    logic seen;
    op[d] = 2'b00; rs1[d] = 32'h11; rs2[d] = 32'h22; req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    flush[d] = 1'b1;
    @(posedge clk); #1;
    flush[d] = 1'b0;
    chk({nm, " idle next cycle"}, busy[d], 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin seen |= resp_valid[d]; @(posedge clk); #1; end
    chk({nm, " no response"}, seen, 0);
  endtask

  task automatic reset_mid(input string nm);
    int n;
    logic seen;
    op[0] = 2'b11; rs1[0] = 32'hDEAD; rs2[0] = 32'hBEEF; req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk({nm, " resp_valid"}, resp_valid[0], 0);
    chk({nm, " busy"}, busy[0], 0);
    chk({nm, " req_ready"}, req_ready[0], 1);
    chk({nm, " resp_data"}, resp_data[0], 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin seen |= resp_valid[0]; @(posedge clk); #1; end
    chk({nm, " no response"}, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; resp_ready = '0; flush = '0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset resp_data", resp_data[0], 0);
    chk("reset resp_err", resp_err[0], 0);
    chk("reset start", start_obs[0], 0);
    rst_n = 1'b1;
    #1;
    chk("release req_ready", req_ready[0], 1);
    chk("release busy", busy[0], 0);
    @(posedge clk); #1;

    do_req(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 7, 0, "mulhu max");
    do_req(0, 2'b01, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 7, 0, "mulh -1x2");
    do_req(0, 2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 7, 0, "mulhsu -1x2");
    do_req(0, 2'b11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0, 7, 0, "mulhu big x2");
    do_req(0, 2'b00, 32'h00012345, 32'h00010000, 32'h23450000, 1'b0, 7, 5, "mul hold");
    do_req(0, 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 7, 0, "mul -3x7");
    flush_op(0, 3, "flush in wait");
    do_req(0, 2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 7, 0, "after flush");
    flush_op(0, 1, "flush in issue");
    reset_mid("reset mid-op");
    do_req(1, 2'b11, 32'h10, 32'h20, 32'h0, 1'b1, MW1 + 2, 2, "timeout");
    do_req(0, 2'b01, 32'd7, 32'd9, 32'h0, 1'b0, 7, 0, "mulh 7x9");
    begin
      int s;
      s = starts0;
      do_req(0, 2'b00, 32'd7, 32'd9, 32'd63, 1'b0, HIT_LAT, 0, "mul 7x9");
      chk("mul 7x9 start pulses", starts0 - s, HIT_STARTS);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: cycles allowed after start before declaring a multiplier timeout.
REQ-002 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-006 SHALL have port op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port rs1, rs2  input  32 each  operands; rs1 is multiplicand, rs2 is multiplier.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port resp_valid  output  1  result present.
REQ-010 SHALL have port resp_ready  input  1  consumer takes result.
REQ-011 SHALL have port resp_data  output  32  result word.
REQ-012 SHALL have port resp_err  output  1  timeout flag, valid with resp_valid.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL use states IDLE, ISSUE, WAIT, CAPTURE, RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid&&req_ready.
REQ-016 SHALL, on accept, register op, rs1 and rs2, then go to ISSUE.
REQ-017 SHALL, in ISSUE, drive multiplier start high for exactly one cycle with the registered operands.
REQ-018 SHALL drive is_signed as follows: MUL 2'b00, MULH 2'b11, MULHSU 2'b10, MULHU 2'b00; bit1 applies to rs1 and bit0 to rs2.
REQ-019 SHALL go ISSUE->WAIT, and WAIT->CAPTURE in the cycle multiplier finished is first seen high.
REQ-020 SHALL, in CAPTURE (the cycle after finished), sample the 64-bit product and go to RESP.
REQ-021 SHALL, in RESP, set resp_data to product[31:0] for MUL and to product[63:32] otherwise.
REQ-022 SHALL, in RESP, hold resp_valid high with stable resp_data and resp_err until resp_ready, then go to IDLE.
REQ-023 SHALL produce a minimum miss latency of accept -> resp_valid equal to the multiplier latency plus 3 cycles.
REQ-024 SHALL, if finished is not seen within MAX_WAIT cycles of start, go to RESP with resp_err=1 and resp_data=0.
REQ-025 SHALL, on flush in any state, return to IDLE next cycle, deassert resp_valid, issue no start, and drop any result.
REQ-026 SHALL let flush take priority over a simultaneous accept, finished or resp_ready.
REQ-027 SHALL NOT allow back-to-back accept: the earliest next accept is the cycle after the RESP handshake.

Reset
REQ-028 SHALL, while nRST=0, force state IDLE, req_ready=1 after release, resp_valid=0, resp_data=0, resp_err=0, busy=0, start=0, and all operand/product registers 0.
REQ-029 SHALL, on reset asserted mid-operation, abandon the operation and produce no response.

Configuration
REQ-030 SHALL, with MUL_RESULT_CACHE_EN defined, keep one entry holding {rs1, rs2, is_signed, product[63:0], valid}, written in CAPTURE.
REQ-031 SHALL, with the cache enabled, count a hit when rs1 and rs2 match and either op is MUL or is_signed matches; on a hit, skip ISSUE/WAIT and go IDLE->RESP one cycle after accept.
REQ-032 SHALL invalidate the cache entry on flush, on timeout, and on reset.
REQ-033 SHALL, with MUL_RESULT_CACHE_EN undefined, contain no cache storage, and every request SHALL take the miss path.

Structure
REQ-034 SHALL place the op encoding enum, the state enum and the is_signed mapping constants in the shared package rv32m_pkg.
REQ-035 SHALL instantiate exactly one sub-module, pp_mul32, as the datapath, driven by the start, operand and is_signed registers.

Verification
REQ-036 SHALL cover: MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> resp_data=0xFFFFFFFE, resp_err=0.
REQ-037 SHALL cover: MULH rs1=0xFFFFFFFF (-1), rs2=2 -> resp_data=0xFFFFFFFF; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-038 SHALL cover: MUL rs1=0x00012345, rs2=0x00010000 -> resp_data=0x23450000, with resp_ready held low 5 cycles -> data stable and no new accept.
REQ-039 SHALL cover: flush asserted in WAIT -> IDLE next cycle, no resp_valid, next request returns correct data.
REQ-040 SHALL cover: finished tied low -> resp_err=1 and resp_data=0 exactly MAX_WAIT cycles after start, plus the RESP cycle.
REQ-041 SHALL cover (cache enabled): MULH 7x9 followed by MUL 7x9 -> second result=63, no second start pulse, resp_valid one cycle after accept.
